// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// requester IDs and the supported read-latency range.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: on contention the port that was
// not served last wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last_served,
  output logic winner,
  output logic any
);

  // Pick the winner; a lone requester always wins
  always_comb begin
    any    = f_req | d_req;
    winner = REQ_F;
    if (f_req && d_req) begin
      winner = (last_served == REQ_F) ? REQ_D : REQ_F;
    end else if (d_req) begin
      winner = REQ_D;
    end else begin
      winner = REQ_F;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between instruction fetch (F) and data
// access (D); serialises accesses and absorbs the fixed read latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

  state_e     state_r;
  logic [2:0] cnt_r;
  logic       owner_r;
  logic       last_served_r;
  logic       winner_s;
  logic       any_s;

  rr_arb2 u_rr_arb2 (
    .f_req       (f_req),
    .d_req       (d_req),
    .last_served (last_served_r),
    .winner      (winner_s),
    .any         (any_s)
  );

  // Transaction FSM; every output is a register updated here
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 3'd0;
      owner_r       <= REQ_F;
      last_served_r <= REQ_D;
      f_gnt         <= 1'b0;
      f_valid       <= 1'b0;
      f_rdata       <= '0;
      d_gnt         <= 1'b0;
      d_valid       <= 1'b0;
      d_rdata       <= '0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
    end else begin
      f_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            owner_r <= winner_s;
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            state_r <= ST_ISSUE;
            if (winner_s == REQ_D) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              d_gnt     <= 1'b1;
            end else begin
              mem_addr  <= f_addr;
              mem_we    <= 1'b0;
              f_gnt     <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // mem_we still holds this transaction's direction here
          if (mem_we) begin
            state_r <= ST_DONE;
            if (owner_r == REQ_D) begin
              d_valid <= 1'b1;
            end else begin
              f_valid <= 1'b1;
            end
          end else if (RD_LAT > 1) begin
            cnt_r   <= CNT_LOAD;
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_CAPTURE;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            state_r <= ST_CAPTURE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_CAPTURE: begin
          state_r <= ST_DONE;
          if (owner_r == REQ_D) begin
            d_rdata <= mem_rdata;
            d_valid <= 1'b1;
          end else begin
            f_rdata <= mem_rdata;
            f_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          last_served_r <= owner_r;
          busy          <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous instruction/data memory between two requesters: instruction fetch (F) and LD/ST data access (D).
- Sits between the processor control/datapath and memory; the control unit raises requests and waits on per-port valid pulses.
- Serialises accesses, applies round-robin arbitration on contention, and handles the memory's fixed read latency.

Parameters:
- DATA_W, 16, memory word / data width
- ADDR_W, 7, memory address width
- RD_LAT, 1, memory read latency in cycles (legal 1..7): rdata valid RD_LAT cycles after the cycle mem_en is high

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request; held until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  one-cycle pulse: fetch accepted
- f_valid  out  1  one-cycle pulse: f_rdata valid
- f_rdata  out  DATA_W  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_valid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_W  loaded word
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_we  out  1  memory write enable; qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset (any time, including mid-transaction) forces IDLE, zeroes every output, rdata register and counter, sets last_served = D, and discards the in-flight transaction with no valid pulse.
- FSM:
  - IDLE: if f_req or d_req, pick the winner, latch addr/we/wdata into the mem_* registers and the owner ID, then go to ISSUE. Otherwise stay.
  - ISSUE: mem_en=1 for one cycle; owner's gnt=1 this same cycle. On a write, mem_we=1 and next state is DONE. On a read, load cnt=RD_LAT-1 and go to WAIT if RD_LAT>1, else to CAPTURE.
  - WAIT: decrement cnt; at cnt==1 go to CAPTURE.
  - CAPTURE: mem_rdata is valid this cycle; latch it into the owner's rdata register at the clock edge; go to DONE.
  - DONE: owner's valid=1 for one cycle; update last_served=owner; go to IDLE.
- Latency (request first seen high in IDLE at cycle 0):
  - Read: gnt at cycle 1, mem_rdata at cycle 1+RD_LAT, valid at cycle 2+RD_LAT.
  - Write: gnt and mem_we at cycle 1, valid at cycle 2.
  - Next request is sampled in IDLE at cycle 3+RD_LAT (read) or 3 (write).
- Arbitration: only one requester high means it wins. Both high means the port not equal to last_served wins; after reset F wins first. Requests are sampled only in IDLE.
- Request rules:
  - A request dropped before gnt is withdrawn with no effect.
  - Requester inputs are don't-care after gnt.
  - A request held high after its own valid is treated as a new transaction.
- mem_addr, mem_we and mem_wdata hold from ISSUE until the next ISSUE. mem_we is cleared in the cycle after ISSUE.
- f_rdata and d_rdata hold their last loaded value until the next read for that port. A store never modifies d_rdata.
- gnt and valid are never high on both ports in the same cycle. Exactly one mem_en occurs per gnt.
- cnt width is 3 bits, which covers RD_LAT up to 7.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, ISSUE, WAIT, CAPTURE, DONE
  - requester ID constants REQ_F=0, REQ_D=1
  - RD_LAT legal range limits
- One natural sub-module: rr_arb2, a combinational 2-way round-robin picker. Inputs: f_req, d_req, last_served. Outputs: winner, any.

Test Plan:
- Reset, then f_req=1 with f_addr=0x05, mem holding 0x1234, RD_LAT=1 -> f_gnt at cycle 1, mem_en/mem_addr=0x05 at cycle 1, f_valid at cycle 3 with f_rdata=0x1234, busy high cycles 1..3.
- d_req with d_we=1, d_addr=0x10, d_wdata=0xBEEF -> mem_en=mem_we=1 with addr 0x10 and data 0xBEEF at cycle 1, d_valid at cycle 2, d_rdata unchanged.
- f_req and d_req both held from reset -> F granted first, then D, then F; grants alternate with no port starved; never two valids in one cycle.
- RD_LAT=3, load from 0x20 returning 0x00AA -> mem_en at cycle 1, d_valid at cycle 5 with d_rdata=0x00AA, exactly one mem_en.
- Reset asserted (low) in WAIT during a fetch -> all outputs 0 immediately (asynchronous); no f_valid after release; next f_req serviced normally with F priority.
- d_req pulsed for one cycle while a fetch is busy, then dropped -> never granted; no mem_en for D; arbiter returns to IDLE with busy=0.
